// File: rtl/apb_ctrl_pkg.sv
// Shared types and default sizing for the APB master controller.
// The unmapped slave window is the one the interconnect never answers.
package apb_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  localparam logic [2:0] UNMAPPED_WIN = 3'd0;
endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to the
// requester that was not granted last. The pointer moves only on an accepted grant.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);
  logic last;  // 1 = requester 1 won the previous grant

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (adv && (|gnt)) begin
      last <= gnt[1];
    end
  end
endmodule

// File: rtl/apb_master_ctrl.sv
// APB master: arbitrates two requesters and runs each transfer through
// IDLE -> SETUP -> ACCESS, aborting an ACCESS phase that outlasts TIMEOUT cycles.
module apb_master_ctrl
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [1:0]          req_wr,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   paddr,
  output logic                pwrite,
  output logic                psel,
  output logic                penable,
  output logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);
  localparam int CNT_W = $clog2(TIMEOUT);

  state_t             state, state_nxt;
  logic [1:0]         arb_gnt;
  logic               arb_adv;
  logic               owner;
  logic [CNT_W-1:0]   wait_cnt;
  logic               done, abort;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_wr;

  rr_arbiter_2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .adv (arb_adv),
    .gnt (arb_gnt)
  );

  // Grants are only offered while idle and never while reset is held.
  assign arb_adv = (state == IDLE) && !rst;
  assign gnt     = arb_adv ? arb_gnt : 2'b00;

  assign sel_addr  = gnt[1] ? req_addr[ADDR_W +: ADDR_W]   : req_addr[0 +: ADDR_W];
  assign sel_wdata = gnt[1] ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
  assign sel_wr    = gnt[1] ? req_wr[1] : req_wr[0];

  assign psel    = (state != IDLE);
  assign penable = (state == ACCESS);

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE:   if (|gnt) state_nxt = SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        // pready wins over the timeout when both land in the same cycle.
        done  = pready;
        abort = !pready && (wait_cnt == CNT_W'(TIMEOUT - 1));
        if (done || abort) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      owner     <= 1'b0;
      wait_cnt  <= '0;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= 2'b00;
      if (|gnt) begin
        paddr  <= sel_addr;
        pwdata <= sel_wdata;
        pwrite <= sel_wr;
        owner  <= gnt[1];
      end
      if (state == SETUP) begin
        wait_cnt <= '0;
      end else if ((state == ACCESS) && !pready) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (done || abort) begin
        rsp_valid <= owner ? 2'b10 : 2'b01;
        rsp_rdata <= (done && !pwrite) ? prdata : '0;
        rsp_err   <= done ? pslverr : 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: a behavioural APB slave, directed
// transfers with per-cycle phase checks, and a response scoreboard keyed by cycle.
module tb_apb_master_ctrl;
  import apb_ctrl_pkg::*;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int EW      = 51;  // {cycle[15:0], rsp_valid[1:0], err, rdata[31:0]}

  logic                clk;
  logic                rst;
  logic [1:0]          req;
  logic [1:0]          req_wr;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          gnt;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic [ADDR_W-1:0]   paddr;
  logic                pwrite;
  logic                psel;
  logic                penable;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W-1:0]   prdata;
  logic                pready;
  logic                pslverr;

  apb_master_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .psel      (psel),
    .penable   (penable),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_bad = 0;
  logic [15:0]   cyc   = 16'd0;

  // Slave behaviour knobs
  int          slv_wait  = 0;
  logic        slv_err   = 1'b0;
  logic [31:0] slv_rdata = 32'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- APB slave model ----------------
  // Answers on ACCESS cycle index slv_wait (window 7: index 0, window 0: never).
  initial begin
    int         k;
    logic [2:0] win;
    k = 0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    forever begin
      @(negedge clk);
      if (psel && penable) begin
        win     = paddr[10:8];
        pready  = (win != UNMAPPED_WIN) && (k == ((win == 3'd7) ? 0 : slv_wait));
        pslverr = pready ? slv_err : 1'b0;
        prdata  = pready ? slv_rdata : $urandom;
        k++;
      end else begin
        k       = 0;
        pready  = (psel && !penable) ? 1'($urandom_range(0, 1)) : 1'b0;
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      cyc = cyc + 16'd1;
      #1;
      check("gnt_not_both", {63'd0, gnt == 2'b11}, 64'd0);
      if (rsp_valid !== 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {62'd0, rsp_valid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_cycle", {48'd0, cyc}, {48'd0, e[50:35]});
          check("rsp_valid", {62'd0, rsp_valid}, {62'd0, e[34:33]});
          check("rsp_err", {63'd0, rsp_err}, {63'd0, e[32]});
          check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e[31:0]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issues one transfer from an idle bus and checks every phase until the response.
  task automatic run_xfer(input int r, input logic wr, input logic [11:0] addr,
                          input logic [31:0] wdata);
    int          lat;
    int          w;
    logic        e_err;
    logic [31:0] e_rd;
    logic [1:0]  e_vld;
    w = (addr[10:8] == 3'd7) ? 0 : slv_wait;
    if (addr[10:8] == UNMAPPED_WIN || w >= TIMEOUT) begin
      lat = TIMEOUT + 2; e_err = 1'b1; e_rd = 32'h0;
    end else begin
      lat = 3 + w; e_err = slv_err; e_rd = wr ? 32'h0 : slv_rdata;
    end
    e_vld = 2'(1 << r);
    req_wr[r]                  = wr;
    req_addr[r*ADDR_W +: ADDR_W]  = addr;
    req_wdata[r*DATA_W +: DATA_W] = wdata;
    req[r]                     = 1'b1;
    #1;
    check("gnt", {62'd0, gnt}, {62'd0, e_vld});
    check("psel_idle", {63'd0, psel}, 64'd0);
    exp_q.push_back({cyc + 16'(lat), e_vld, e_err, e_rd});
    tick();
    req[r] = 1'b0;
    for (int k = 1; k < lat; k++) begin
      check("psel", {63'd0, psel}, 64'd1);
      check("penable", {63'd0, penable}, {63'd0, k >= 2});
      check("paddr", {52'd0, paddr}, {52'd0, addr});
      check("pwrite", {63'd0, pwrite}, {63'd0, wr});
      check("pwdata", {32'd0, pwdata}, {32'd0, wdata});
      tick();
    end
    check("psel_end", {63'd0, psel}, 64'd0);
    #1;
    check("rsp_seen", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]  exp_g;
    logic [11:0] a;
    rst = 1'b1; req = 2'b00; req_wr = 2'b00; req_addr = '0; req_wdata = '0;
    tick(); tick();
    req = 2'b11;
    #1;
    check("gnt_in_reset", {62'd0, gnt}, 64'd0);
    tick();
    req = 2'b00;
    rst = 1'b0;
    #1;
    check("rst_psel", {63'd0, psel}, 64'd0);
    check("rst_penable", {63'd0, penable}, 64'd0);
    check("rst_paddr", {52'd0, paddr}, 64'd0);
    check("rst_pwdata", {32'd0, pwdata}, 64'd0);
    check("rst_pwrite", {63'd0, pwrite}, 64'd0);
    check("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    check("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    check("rst_rsp_err", {63'd0, rsp_err}, 64'd0);

    // Zero-wait read
    slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'hDEADBEEF;
    run_xfer(0, 1'b0, 12'h100, 32'h0);

    // Wait-state write
    slv_wait = 3; slv_rdata = 32'h0BAD_0BAD;
    run_xfer(1, 1'b1, 12'h200, 32'hA5A5A5A5);

    // Both requesters held: grants alternate 0,1,0,1 every 3 cycles
    slv_wait = 0; slv_rdata = 32'h1357_9BDF;
    req_wr = 2'b00; req_addr = {12'h710, 12'h700};
    req = 2'b11;
    #1;
    exp_g = 2'b01;
    for (int c = 0; c < 10; c++) begin
      if (c % 3 == 0) begin
        check("arb_gnt", {62'd0, gnt}, {62'd0, exp_g});
        exp_q.push_back({cyc + 16'd3, exp_g, 1'b0, slv_rdata});
        exp_g = ~exp_g;
      end else begin
        check("arb_gnt_busy", {62'd0, gnt}, 64'd0);
      end
      tick();
    end
    req = 2'b00;
    drain(10);

    // Timeout on the unmapped window
    run_xfer(0, 1'b0, 12'h050, 32'h0);

    // pready with pslverr in the last legal ACCESS cycle
    slv_wait = TIMEOUT - 1; slv_err = 1'b1; slv_rdata = 32'h1234_5678;
    run_xfer(1, 1'b0, 12'h300, 32'h0);

    // Reset in the middle of a stalled transfer
    slv_wait = 10; slv_err = 1'b0;
    req_wr[0] = 1'b0; req_addr[11:0] = 12'h400; req[0] = 1'b1;
    #1;
    check("kill_gnt", {62'd0, gnt}, 64'd1);
    tick();
    req[0] = 1'b0;
    tick(); tick();
    check("kill_penable", {63'd0, penable}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("kill_psel", {63'd0, psel}, 64'd0);
    check("kill_penable0", {63'd0, penable}, 64'd0);
    check("kill_paddr", {52'd0, paddr}, 64'd0);
    check("kill_rsp_err", {63'd0, rsp_err}, 64'd0);
    check("kill_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    for (int k = 0; k < 12; k++) begin
      check("kill_no_rsp", {62'd0, rsp_valid}, 64'd0);
      tick();
    end
    slv_wait = 1; slv_rdata = 32'hCAFE_F00D;
    run_xfer(0, 1'b1, 12'h7AC, 32'h600D_F00D);
    run_xfer(1, 1'b0, 12'h1F0, 32'h0);

    // Randomised transfers across mapped windows
    for (int i = 0; i < 8; i++) begin
      slv_wait  = $urandom_range(0, 4);
      slv_err   = 1'($urandom_range(0, 1));
      slv_rdata = $urandom;
      a         = 12'($urandom);
      a[10:8]   = 3'($urandom_range(1, 7));
      run_xfer($urandom_range(0, 1), 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
